// File: rtl/matrix_mult.sv
// Sequential matrix multiplier C = A x B built around one shared
// multiply-accumulate unit; one MAC per clock, k fastest, then c, then r.
module matrix_mult #(
    parameter int MATRIX_SIZE_M = 3,
    parameter int MATRIX_SIZE_K = 2,
    parameter int MATRIX_SIZE_N = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int SIGNED        = 0,
    parameter int SATURATE      = 0
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst,
    input  logic                                               i_calc_cmd,
    input  logic [MATRIX_SIZE_M*MATRIX_SIZE_K*DATA_WIDTH-1:0] i_matrix_a,
    input  logic [MATRIX_SIZE_K*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrix_b,
    output logic [MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] o_matrix,
    output logic                                               o_ready,
    output logic                                               o_busy,
    output logic                                               o_overflow
);

    localparam int M  = MATRIX_SIZE_M;
    localparam int K  = MATRIX_SIZE_K;
    localparam int N  = MATRIX_SIZE_N;
    localparam int DW = DATA_WIDTH;
    localparam int ACC_WIDTH = 2 * DW + $clog2(K) + 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam bit SGN = (SIGNED != 0);
    localparam bit SAT = (SATURATE != 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [DW-1:0]        a_mem   [M][K];
    logic [DW-1:0]        b_mem   [K][N];
    logic [DW-1:0]        res_buf [M][N];
    logic [RW-1:0]        r_idx;
    logic [CW-1:0]        c_idx;
    logic [KW-1:0]        k_idx;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_acc;

    logic [DW-1:0]        a_el;
    logic [DW-1:0]        b_el;
    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] sum;
    logic [DW-1:0]        conv;
    logic                 ovf_el;

    assign o_busy = (state != IDLE);

    // Low ACC_WIDTH bits of the product are identical for signed and
    // unsigned operands once they are extended, so one multiplier serves both.
    always_comb begin
        a_el   = a_mem[r_idx][k_idx];
        b_el   = b_mem[k_idx][c_idx];
        a_ext  = {{(ACC_WIDTH-DW){SGN & a_el[DW-1]}}, a_el};
        b_ext  = {{(ACC_WIDTH-DW){SGN & b_el[DW-1]}}, b_el};
        prod   = a_ext * b_ext;
        sum    = acc + prod;
        conv   = sum[DW-1:0];
        ovf_el = 1'b0;
        if (SGN) begin
            ovf_el = ~((&sum[ACC_WIDTH-1:DW-1]) | ~(|sum[ACC_WIDTH-1:DW-1]));
        end else begin
            ovf_el = |sum[ACC_WIDTH-1:DW];
        end
        if (SAT && ovf_el) begin
            if (SGN) begin
                conv = sum[ACC_WIDTH-1] ? {1'b1, {(DW-1){1'b0}}}
                                        : {1'b0, {(DW-1){1'b1}}};
            end else begin
                conv = '1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            r_idx      <= '0;
            c_idx      <= '0;
            k_idx      <= '0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            o_matrix   <= '0;
            o_ready    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_calc_cmd) begin
                        for (int r = 0; r < M; r++)
                            for (int k = 0; k < K; k++)
                                a_mem[r][k] <= i_matrix_a[(r*K+k)*DW +: DW];
                        for (int k = 0; k < K; k++)
                            for (int c = 0; c < N; c++)
                                b_mem[k][c] <= i_matrix_b[(k*N+c)*DW +: DW];
                        r_idx   <= '0;
                        c_idx   <= '0;
                        k_idx   <= '0;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (k_idx == KW'(K-1)) begin
                        res_buf[r_idx][c_idx] <= conv;
                        ovf_acc <= ovf_acc | ovf_el;
                        acc     <= '0;
                        k_idx   <= '0;
                        if (c_idx == CW'(N-1)) begin
                            c_idx <= '0;
                            if (r_idx == RW'(M-1)) begin
                                r_idx <= '0;
                                state <= DONE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            c_idx <= c_idx + 1'b1;
                        end
                    end else begin
                        acc   <= sum;
                        k_idx <= k_idx + 1'b1;
                    end
                end
                DONE: begin
                    for (int r = 0; r < M; r++)
                        for (int c = 0; c < N; c++)
                            o_matrix[(r*N+c)*DW +: DW] <= res_buf[r][c];
                    o_overflow <= ovf_acc;
                    o_ready    <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult.sv
// Bench for matrix_mult: four instances covering signed/unsigned x wrap/clamp,
// checked against an integer reference model.
module tb_matrix_mult;

    localparam int M  = 3;
    localparam int K  = 2;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = M * K * DW;
    localparam int BW = K * N * DW;
    localparam int CW = M * N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [CW-1:0] mat  [4];
    logic          rdy  [4];
    logic          busy [4];
    logic          ovf  [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance g: SIGNED = g/2, SATURATE = g%2.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        matrix_mult #(
            .MATRIX_SIZE_M(M),
            .MATRIX_SIZE_K(K),
            .MATRIX_SIZE_N(N),
            .DATA_WIDTH   (DW),
            .SIGNED       (g / 2),
            .SATURATE     (g % 2)
        ) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_calc_cmd(cmd),
            .i_matrix_a(a),
            .i_matrix_b(b),
            .o_matrix  (mat[g]),
            .o_ready   (rdy[g]),
            .o_busy    (busy[g]),
            .o_overflow(ovf[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [AW-1:0] ma,
                                  input logic [BW-1:0] mb,
                                  input bit sg, input bit st,
                                  output logic [CW-1:0] mc,
                                  output logic mo);
        longint s, va, vb, lo, hi;
        logic [DW-1:0] ea, eb;
        lo = sg ? -(longint'(1) << (DW - 1)) : 0;
        hi = sg ? (longint'(1) << (DW - 1)) - 1 : (longint'(1) << DW) - 1;
        mc = '0;
        mo = 1'b0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < K; k++) begin
                    ea = ma[(r*K+k)*DW +: DW];
                    eb = mb[(k*N+c)*DW +: DW];
                    va = sg ? longint'($signed(ea)) : longint'(ea);
                    vb = sg ? longint'($signed(eb)) : longint'(eb);
                    s += va * vb;
                end
                if (s < lo || s > hi) begin
                    mo = 1'b1;
                    if (st) s = (s < lo) ? lo : hi;
                end
                mc[(r*N+c)*DW +: DW] = s[DW-1:0];
            end
        end
    endfunction

    task automatic run_calc(input logic [AW-1:0] ta, input logic [BW-1:0] tb,
                            input string tag);
        logic [CW-1:0] ec;
        logic          eo;
        int            cnt;
        @(negedge clk);
        a   = ta;
        b   = tb;
        cmd = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, busy[0], 1);
        @(negedge clk);
        cmd = 1'b0;
        a   = {$urandom, $urandom, $urandom};
        b   = {$urandom, $urandom};
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!rdy[0] && cnt < 40);
        check({tag, "_latency"}, cnt, 13);
        for (int g = 0; g < 4; g++) begin
            model(ta, tb, g >= 2, g % 2 == 1, ec, eo);
            check($sformatf("%s_c%0d", tag, g), mat[g], ec);
            check($sformatf("%s_ovf%0d", tag, g), ovf[g], eo);
            check($sformatf("%s_rdy%0d", tag, g), rdy[g], 1);
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            model(ta, tb, g >= 2, g % 2 == 1, ec, eo);
            check($sformatf("%s_pulse%0d", tag, g), rdy[g], 0);
            check($sformatf("%s_hold%0d", tag, g), mat[g], ec);
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        logic [CW-1:0] ec;
        logic          eo;
        int            pulses[$];
        int            busy_lo;
        int            seen;

        rst = 1'b1;
        cmd = 1'b0;
        a   = '0;
        b   = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst_c%0d", g), mat[g], 0);
            check($sformatf("rst_rdy%0d", g), rdy[g], 0);
            check($sformatf("rst_busy%0d", g), busy[g], 0);
            check($sformatf("rst_ovf%0d", g), ovf[g], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        ra = {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        run_calc(ra, {16'd1, 16'd0, 16'd0, 16'd1}, "ident");
        check("ident_eq_a", mat[0], ra);
        check("ident_ovf", ovf[0], 0);

        run_calc(ra, {16'd2, 16'd1, 16'd1, 16'd2}, "b2112");
        check("b2112_const", mat[0],
              {16'd17, 16'd16, 16'd11, 16'd10, 16'd5, 16'd4});

        run_calc({16'd5, 16'd0, 16'hFFFC, 16'd3, 16'd2, 16'hFFFF},
                 {16'd2, 16'd2, 16'hFFFF, 16'd1}, "signed");
        check("signed_const", mat[2],
              {16'd10, 16'd10, 16'hFFF5, 16'hFFFB, 16'd5, 16'd3});

        run_calc({6{16'h7FFF}}, {4{16'h7FFF}}, "max");
        check("max_sat_c", mat[3], {6{16'h7FFF}});
        check("max_sat_ovf", ovf[3], 1);
        check("max_wrap_c", mat[2], {6{16'h0002}});
        check("max_wrap_ovf", ovf[2], 1);

        // Abort mid-computation.
        @(negedge clk);
        a   = {$urandom, $urandom, $urandom};
        b   = {$urandom, $urandom};
        cmd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("abort_c%0d", g), mat[g], 0);
            check($sformatf("abort_rdy%0d", g), rdy[g], 0);
            check($sformatf("abort_busy%0d", g), busy[g], 0);
            check($sformatf("abort_ovf%0d", g), ovf[g], 0);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (rdy[0] || busy[0]) seen++;
        end
        check("abort_quiet", seen, 0);

        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                ra = {$urandom, $urandom, $urandom};
                rb = {$urandom, $urandom};
            end else begin
                for (int e = 0; e < M * K; e++)
                    ra[e*DW +: DW] = DW'($urandom_range(0, 40)) - DW'(20);
                for (int e = 0; e < K * N; e++)
                    rb[e*DW +: DW] = DW'($urandom_range(0, 40)) - DW'(20);
            end
            run_calc(ra, rb, $sformatf("rnd%0d", i));
        end

        // Command held high: back-to-back runs.
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom};
        model(ra, rb, 1'b0, 1'b0, ec, eo);
        busy_lo = 0;
        @(negedge clk);
        a   = ra;
        b   = rb;
        cmd = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (!busy[0]) busy_lo++;
            if (rdy[0]) begin
                pulses.push_back(i);
                check($sformatf("b2b_c%0d", i), mat[0], ec);
            end
        end
        @(negedge clk);
        cmd = 1'b0;
        check("b2b_count", pulses.size(), 2);
        if (pulses.size() >= 2) begin
            check("b2b_first", pulses[0], 13);
            check("b2b_space", pulses[1] - pulses[0], 14);
        end
        check("b2b_busy_lo", busy_lo, 2);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (rdy[0]) seen++;
        end
        check("b2b_drain", seen, 1);
        check("b2b_idle", busy[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
